// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: round-robin sharing of one memory port between two masters with in-order read response routing
module main_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_write,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_data,
  output logic              m0_resp_valid,
  output logic [DATA_W-1:0] m0_resp_data,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_write,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_data,
  output logic              m1_resp_valid,
  output logic [DATA_W-1:0] m1_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              err_unexpected_resp
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  logic [PW:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [MAX_OUTSTANDING-1:0] owner;
  logic last_grant, slot_free, full, elig0, elig1, grant0, grant1, push, pop, head;
  // Eligibility and round-robin grant; the full check uses the registered count so a same-cycle pop never frees a slot
  always_comb begin
    slot_free = !mem_req_valid || mem_req_ready;
    full = count == (PW+1)'(MAX_OUTSTANDING);
    elig0 = m0_req_valid && slot_free && (m0_req_write || !full);
    elig1 = m1_req_valid && slot_free && (m1_req_write || !full);
    grant0 = elig0 && (!elig1 || last_grant);
    grant1 = elig1 && (!elig0 || !last_grant);
    push = grant0 ? !m0_req_write : (grant1 && !m1_req_write);
    pop = mem_resp_valid && count != '0;
    head = owner[rd_ptr];
  end
  assign m0_req_ready = grant0;
  assign m1_req_ready = grant1;
  // Request register: loads the winner, otherwise holds until memory accepts
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr <= '0;
      mem_req_data <= '0;
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      mem_req_valid <= 1'b1;
      mem_req_write <= grant0 ? m0_req_write : m1_req_write;
      mem_req_addr <= grant0 ? m0_req_addr : m1_req_addr;
      mem_req_data <= grant0 ? m0_req_data : m1_req_data;
      last_grant <= grant1;
    end else if (mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end
  // Owner FIFO: records which master issued each outstanding read
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      owner <= '0;
    end else begin
      if (push) owner[wr_ptr] <= grant1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // Registered response routing and sticky unexpected-response flag
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_resp_valid <= 1'b0;
      m1_resp_valid <= 1'b0;
      m0_resp_data <= '0;
      m1_resp_data <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      m0_resp_valid <= pop && !head;
      m1_resp_valid <= pop && head;
      if (pop && !head) m0_resp_data <= mem_resp_data;
      if (pop && head) m1_resp_data <= mem_resp_data;
      err_unexpected_resp <= err_unexpected_resp || (mem_resp_valid && count == '0);
    end
  end
endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter: directed table and corner-case sequences for main_mem_arbiter
module tb_main_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_req_valid, m0_req_ready, m0_req_write, m0_resp_valid;
  logic [31:0] m0_req_addr, m0_req_data, m0_resp_data;
  logic m1_req_valid, m1_req_ready, m1_req_write, m1_resp_valid;
  logic [31:0] m1_req_addr, m1_req_data, m1_resp_data;
  logic mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid, err_unexpected_resp;
  logic [31:0] mem_req_addr, mem_req_data, mem_resp_data;
  int errors = 0, checks = 0;
  main_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_write(m0_req_write),
    .m0_req_addr(m0_req_addr), .m0_req_data(m0_req_data), .m0_resp_valid(m0_resp_valid),
    .m0_resp_data(m0_resp_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_write(m1_req_write),
    .m1_req_addr(m1_req_addr), .m1_req_data(m1_req_data), .m1_resp_valid(m1_resp_valid),
    .m1_resp_data(m1_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .err_unexpected_resp(err_unexpected_resp)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit m0v; logic [31:0] m0a; bit m1v; logic [31:0] m1a; bit mr; bit rv; logic [31:0] rd;
    bit r0; bit r1; bit mv; logic [31:0] ma; bit o0; bit o1; logic [31:0] od; bit err;
  } vec_t;
  vec_t vecs[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input bit m0v, input bit m0w, input logic [31:0] m0a, input bit m1v, input bit m1w,
                        input logic [31:0] m1a, input logic [31:0] m1d, input bit mr, input bit rv, input logic [31:0] rd);
    m0_req_valid = m0v; m0_req_write = m0w; m0_req_addr = m0a; m0_req_data = 32'h0;
    m1_req_valid = m1v; m1_req_write = m1w; m1_req_addr = m1a; m1_req_data = m1d;
    mem_req_ready = mr; mem_resp_valid = rv; mem_resp_data = rd;
  endtask
  task automatic idle(input bit mr);
    set_in(0, 0, 0, 0, 0, 0, 0, mr, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    tick();
    reset = 1'b0;
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst mem_req_addr", mem_req_addr, 0);
    chk("rst mem_req_data", mem_req_data, 0);
    chk("rst mem_req_write", mem_req_write, 0);
    chk("rst m0_resp_valid", m0_resp_valid, 0);
    chk("rst m1_resp_valid", m1_resp_valid, 0);
    chk("rst m0_resp_data", m0_resp_data, 0);
    chk("rst m1_resp_data", m1_resp_data, 0);
    chk("rst err", err_unexpected_resp, 0);
  endtask
  task automatic chk_req(input string name, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
    chk({name, " valid"}, mem_req_valid, v);
    chk({name, " write"}, mem_req_write, w);
    chk({name, " addr"}, mem_req_addr, a);
    chk({name, " data"}, mem_req_data, d);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{0, 0, 1, 32'h10f4, 1, 0, 0,            0, 1, 1, 32'h10f4, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 0, 0,                   0, 0, 0, 32'h10f4, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 0,                   0, 0, 0, 32'h10f4, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 1, 32'h12345678,        0, 0, 0, 32'h10f4, 0, 1, 32'h12345678, 0};
    vecs[4]  = '{0, 0, 0, 0, 1, 0, 0,                   0, 0, 0, 32'h10f4, 0, 0, 0, 0};
    vecs[5]  = '{1, 32'h100, 1, 32'h200, 1, 0, 0,       1, 0, 1, 32'h100, 0, 0, 0, 0};
    vecs[6]  = '{1, 32'h100, 1, 32'h200, 1, 0, 0,       0, 1, 1, 32'h200, 0, 0, 0, 0};
    vecs[7]  = '{1, 32'h100, 1, 32'h200, 1, 0, 0,       1, 0, 1, 32'h100, 0, 0, 0, 0};
    vecs[8]  = '{1, 32'h100, 1, 32'h200, 1, 0, 0,       0, 1, 1, 32'h200, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 1, 1, 32'hd0d0d0d0,        0, 0, 0, 32'h200, 1, 0, 32'hd0d0d0d0, 0};
    vecs[10] = '{0, 0, 0, 0, 1, 1, 32'hd1d1d1d1,        0, 0, 0, 32'h200, 0, 1, 32'hd1d1d1d1, 0};
    vecs[11] = '{0, 0, 0, 0, 1, 1, 32'hd2d2d2d2,        0, 0, 0, 32'h200, 1, 0, 32'hd2d2d2d2, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 1, 32'hd3d3d3d3,        0, 0, 0, 32'h200, 0, 1, 32'hd3d3d3d3, 0};
    vecs[13] = '{0, 0, 0, 0, 1, 0, 0,                   0, 0, 0, 32'h200, 0, 0, 0, 0};
    idle(1);
    tick();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].m0v, 0, vecs[i].m0a, vecs[i].m1v, 0, vecs[i].m1a, 0, vecs[i].mr, vecs[i].rv, vecs[i].rd);
      #1;
      chk($sformatf("v%0d m0_req_ready", i), m0_req_ready, vecs[i].r0);
      chk($sformatf("v%0d m1_req_ready", i), m1_req_ready, vecs[i].r1);
      tick();
      chk($sformatf("v%0d mem_req_valid", i), mem_req_valid, vecs[i].mv);
      chk($sformatf("v%0d mem_req_addr", i), mem_req_addr, vecs[i].ma);
      chk($sformatf("v%0d m0_resp_valid", i), m0_resp_valid, vecs[i].o0);
      chk($sformatf("v%0d m1_resp_valid", i), m1_resp_valid, vecs[i].o1);
      if (vecs[i].o0) chk($sformatf("v%0d m0_resp_data", i), m0_resp_data, vecs[i].od);
      if (vecs[i].o1) chk($sformatf("v%0d m1_resp_data", i), m1_resp_data, vecs[i].od);
      chk($sformatf("v%0d err", i), err_unexpected_resp, vecs[i].err);
    end
    do_reset();
    set_in(0, 0, 0, 1, 1, 32'hf14, 32'h87654321, 0, 0, 0);
    #1;
    chk("bp first m1_req_ready", m1_req_ready, 1);
    tick();
    chk_req("bp load", 1, 1, 32'hf14, 32'h87654321);
    set_in(1, 0, 32'h300, 1, 1, 32'hf18, 32'h1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d m0_req_ready", i), m0_req_ready, 0);
      chk($sformatf("bp%0d m1_req_ready", i), m1_req_ready, 0);
      tick();
      chk_req($sformatf("bp%0d hold", i), 1, 1, 32'hf14, 32'h87654321);
    end
    mem_req_ready = 1;
    #1;
    chk("bp release m0_req_ready", m0_req_ready, 1);
    chk("bp release m1_req_ready", m1_req_ready, 0);
    tick();
    chk_req("bp m0 read", 1, 0, 32'h300, 32'h0);
    m0_req_valid = 0;
    #1;
    chk("bp m1 next m1_req_ready", m1_req_ready, 1);
    tick();
    chk_req("bp m1 write", 1, 1, 32'hf18, 32'h1);
    idle(1);
    tick();
    chk("bp drain mem_req_valid", mem_req_valid, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 32'h1000 + 32'(i * 4), 0, 0, 0, 0, 1, 0, 0);
      #1;
      chk($sformatf("lim%0d m0_req_ready", i), m0_req_ready, 1);
      tick();
      chk($sformatf("lim%0d mem_req_addr", i), mem_req_addr, 32'h1000 + 32'(i * 4));
    end
    set_in(1, 0, 32'h2000, 1, 1, 32'h400, 32'h77, 1, 0, 0);
    #1;
    chk("lim full m0_req_ready", m0_req_ready, 0);
    chk("lim full m1_req_ready", m1_req_ready, 1);
    tick();
    chk_req("lim write", 1, 1, 32'h400, 32'h77);
    set_in(1, 0, 32'h2000, 0, 0, 0, 0, 1, 1, 32'haaaa5555);
    #1;
    chk("lim pop m0_req_ready", m0_req_ready, 0);
    tick();
    chk("lim pop m0_resp_valid", m0_resp_valid, 1);
    chk("lim pop m0_resp_data", m0_resp_data, 32'haaaa5555);
    chk("lim pop m1_resp_valid", m1_resp_valid, 0);
    chk("lim pop mem_req_valid", mem_req_valid, 0);
    set_in(1, 0, 32'h2000, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("lim after m0_req_ready", m0_req_ready, 1);
    tick();
    chk_req("lim after read", 1, 0, 32'h2000, 32'h0);
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55);
    tick();
    chk("err set", err_unexpected_resp, 1);
    chk("err m0_resp_valid", m0_resp_valid, 0);
    chk("err m1_resp_valid", m1_resp_valid, 0);
    idle(1);
    tick();
    chk("err sticky", err_unexpected_resp, 1);
    set_in(1, 0, 32'h10, 0, 0, 0, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 0, 32'h20, 0, 1, 0, 0);
    #1;
    chk("rr2 m1_req_ready", m1_req_ready, 1);
    tick();
    idle(0);
    tick();
    chk("pend mem_req_valid", mem_req_valid, 1);
    chk("pend mem_req_addr", mem_req_addr, 32'h20);
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h66);
    tick();
    chk("late err", err_unexpected_resp, 1);
    chk("late m0_resp_valid", m0_resp_valid, 0);
    chk("late m1_resp_valid", m1_resp_valid, 0);
    idle(1);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/main_mem_arbiter.md
Name: main_mem_arbiter

Overview:
- Shares the single main-memory port between two requesters: master 0 (instruction fetch, read-only in practice) and master 1 (MemExecElement load/store path).
- Round-robin arbitration into a one-entry registered request stage.
- Tracks outstanding reads in an owner FIFO so that in-order read responses are routed back to the requester that issued them.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_OUTSTANDING, 4, owner-FIFO depth and maximum number of reads in flight (power of two, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m0_req_valid  in  1  master 0 request valid.
- m0_req_ready  out  1  master 0 request accepted this cycle (valid&&ready).
- m0_req_write  in  1  1 = store, 0 = load.
- m0_req_addr  in  ADDR_W  master 0 address.
- m0_req_data  in  DATA_W  master 0 store data.
- m0_resp_valid  out  1  master 0 read data valid (one-cycle pulse).
- m0_resp_data  out  DATA_W  master 0 read data.
- m1_req_valid, m1_req_ready, m1_req_write, m1_req_addr, m1_req_data, m1_resp_valid, m1_resp_data: same as m0_*, for master 1.
- mem_req_valid  out  1  request to memory valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  request type.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_data  out  DATA_W  store data.
- mem_resp_valid  in  1  read response valid; in order; no backpressure.
- mem_resp_data  in  DATA_W  read response data.
- err_unexpected_resp  out  1  sticky; set when a response arrives with the owner FIFO empty.

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk):
  - Clears the request register (mem_req_valid=0), the owner FIFO (count=0) and the rr pointer (last_grant=1, so m0 wins the first tie).
  - Drives m*_resp_valid=0 and err_unexpected_resp=0.
  - mem_req_addr/data/write reset to 0; m*_resp_data reset to 0.
- Request register stage:
  - slot_free = !mem_req_valid || mem_req_ready.
  - When a request is granted it loads at the posedge; mem_req_valid goes high the next cycle.
  - Once valid, the register holds its contents stable until mem_req_ready is high.
- Eligibility: master i is eligible iff mi_req_valid && slot_free && (mi_req_write || count < MAX_OUTSTANDING).
  - count includes the read currently in the request register.
  - A pop in the same cycle does not relax the full check.
- Grant:
  - One eligible master: it wins.
  - Both eligible: the master != last_grant wins.
  - last_grant updates only on a grant.
  - mi_req_ready = grant_i. This is combinational from mi_req_valid, mem_req_ready and count; it never depends on the other master's ready.
  - At most one ready is high per cycle.
- Owner FIFO:
  - A granted read pushes the master id at the grant edge.
  - mem_resp_valid pops the head id.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - Writes never push.
- Response routing:
  - mem_resp_valid at posedge N with head=i produces mi_resp_valid=1 and mi_resp_data=mem_resp_data during cycle N+1 (registered, 1-cycle latency).
  - The other master's resp_valid stays 0.
  - resp_valid is never high for two masters in the same cycle.
- Unexpected response: mem_resp_valid with count==0 causes no pop, no resp_valid, and sets err_unexpected_resp (held until reset).
- Ordering:
  - Per-master requests reach memory in acceptance order.
  - A write and a later read from different masters are ordered by grant order. No reordering or bypass.
- Reset mid-operation:
  - In-flight state is discarded.
  - A pending mem_req_valid drops the cycle after reset is sampled.
  - Late responses to pre-reset reads raise err_unexpected_resp.
- Throughput: one grant per cycle when mem_req_ready is held high.

Test Plan:
- Single read: m1 read addr 0x000010f4, mem_req_ready=1, memory returns 0x12345678 three cycles later -> mem_req_valid/addr 0x000010f4 one cycle after the grant; m1_resp_valid pulses once with 0x12345678; m0_resp_valid stays 0.
- Contention: m0 and m1 both hold reads (0x100, 0x200) for 4 grants -> grant order m0, m1, m0, m1; responses D0..D3 route to m0, m1, m0, m1 in order.
- Backpressure: mem_req_ready=0 for 5 cycles with m1 store addr 0x00000f14, data 87654321 registered -> mem_req_* stable for all 5 cycles; both m*_req_ready=0 until ready returns.
- Outstanding limit: 4 reads issued with no responses -> 5th read not granted (ready=0) while a concurrent m1 write is still granted; one response -> the read is granted the following cycle.
- Error/reset: mem_resp_valid with empty FIFO -> err_unexpected_resp=1 and no resp_valid; then reset with 2 reads in flight -> count=0 and mem_req_valid=0 after reset; a late response sets the error again.
